// File: rtl/kdma_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : kdma_ctrl
// Brief    : Sprite-DMA controller and k6502 system-bus arbiter. Optional
//            cycle-parity alignment stage enabled by macro KDMA_ALIGN_EN.
// Revision : 1.0 - initial release
// ============================================================================
module kdma_ctrl #(
    parameter logic [15:0] DMA_REG_ADDR = 16'h4014,
    parameter logic [15:0] DEST_ADDR    = 16'h2004,
    parameter int unsigned XFER_LEN     = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] cpu_a,
    input  logic [7:0]  cpu_dout,
    input  logic        cpu_rw,
    output logic        cpu_rdy,
    output logic [15:0] bus_a,
    output logic [7:0]  bus_dout,
    output logic        bus_rw,
    input  logic [7:0]  bus_din,
    output logic        dma_active
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HALT  = 3'd1,
        ALIGN = 3'd2,
        READ  = 3'd3,
        WRITE = 3'd4
    } state_t;

    localparam logic [8:0] LAST_IDX = 9'(XFER_LEN - 1);

    state_t      state;
    logic [8:0]  idx;
    logic [7:0]  page;
    logic [7:0]  latch;
`ifdef KDMA_ALIGN_EN
    logic        cyc_par;
`endif

    // cpu_rdy / dma_active are registered alongside the state they decode.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            idx        <= 9'd0;
            page       <= 8'd0;
            latch      <= 8'd0;
            cpu_rdy    <= 1'b1;
            dma_active <= 1'b0;
`ifdef KDMA_ALIGN_EN
            cyc_par    <= 1'b0;
`endif
        end else begin
`ifdef KDMA_ALIGN_EN
            cyc_par <= ~cyc_par;
`endif
            case (state)
                IDLE: begin
                    if (cpu_rw && (cpu_a == DMA_REG_ADDR)) begin
                        page    <= cpu_dout;
                        idx     <= 9'd0;
                        state   <= HALT;
                        cpu_rdy <= 1'b0;
                    end
                end
                HALT: begin
                    // The CPU only halts on a read, so wait out any write burst.
                    if (!cpu_rw) begin
                        dma_active <= 1'b1;
`ifdef KDMA_ALIGN_EN
                        state      <= cyc_par ? READ : ALIGN;
`else
                        state      <= READ;
`endif
                    end
                end
                ALIGN: begin
                    state <= READ;
                end
                READ: begin
                    latch <= bus_din;
                    state <= WRITE;
                end
                WRITE: begin
                    if (idx == LAST_IDX) begin
                        state      <= IDLE;
                        cpu_rdy    <= 1'b1;
                        dma_active <= 1'b0;
                    end else begin
                        idx   <= idx + 9'd1;
                        state <= READ;
                    end
                end
                default: begin
                    state      <= IDLE;
                    cpu_rdy    <= 1'b1;
                    dma_active <= 1'b0;
                end
            endcase
        end
    end

    // Source address never carries into the page: only idx[7:0] is used.
    always_comb begin
        bus_a    = cpu_a;
        bus_dout = cpu_dout;
        bus_rw   = cpu_rw;
        case (state)
            ALIGN: begin
                bus_rw = 1'b0;
            end
            READ: begin
                bus_a    = {page, idx[7:0]};
                bus_dout = latch;
                bus_rw   = 1'b0;
            end
            WRITE: begin
                bus_a    = DEST_ADDR;
                bus_dout = latch;
                bus_rw   = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_kdma_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_kdma_ctrl
// Brief    : Scoreboard bench for kdma_ctrl (256-byte and 4-byte instances).
// Revision : 1.0 - initial release
// ============================================================================
module tb_kdma_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] cpu_a;
    logic [7:0]  cpu_dout;
    logic        cpu_rw;

    logic        m_rdy, m_rw, m_act;
    logic [15:0] m_a;
    logic [7:0]  m_dout, m_din;
    logic        s_rdy, s_rw, s_act;
    logic [15:0] s_a;
    logic [7:0]  s_dout, s_din;

    // Memory image: byte at {p,i} is i ^ p ^ 8'h58 (page $02 gives idx ^ $5A).
    assign m_din = m_a[7:0] ^ m_a[15:8] ^ 8'h58;
    assign s_din = s_a[7:0] ^ s_a[15:8] ^ 8'h58;

    always #5 clk = ~clk;

    kdma_ctrl u_main (
        .clk(clk), .rst_n(rst_n), .cpu_a(cpu_a), .cpu_dout(cpu_dout),
        .cpu_rw(cpu_rw), .cpu_rdy(m_rdy), .bus_a(m_a), .bus_dout(m_dout),
        .bus_rw(m_rw), .bus_din(m_din), .dma_active(m_act)
    );

    kdma_ctrl #(.XFER_LEN(4)) u_short (
        .clk(clk), .rst_n(rst_n), .cpu_a(cpu_a), .cpu_dout(cpu_dout),
        .cpu_rw(cpu_rw), .cpu_rdy(s_rdy), .bus_a(s_a), .bus_dout(s_dout),
        .bus_rw(s_rw), .bus_din(s_din), .dma_active(s_act)
    );

    typedef struct {
        logic [15:0] a;
        logic [7:0]  d;
    } xfer_t;

    xfer_t qm[$];
    xfer_t qs[$];
    int    stm[$];
    int    sts[$];
    xfer_t e_m, e_s;
    logic [15:0] m_last_rd, s_last_rd;
    int    checks = 0;
    int    errors = 0;
    int    wr_seen = 0;
    int    pcnt = 0;
    int    run_m = 0;
    int    run_s = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic miss(input string name);
        checks++;
        errors++;
        $display("FAIL %s: actual=event required=none/other", name);
    endtask

    always @(posedge clk) begin
        if (!rst_n) pcnt <= 0;
        else        pcnt <= pcnt + 1;
    end

    // Bus monitors: pass-through when idle, read/write pairs when DMA owns the bus.
    always @(negedge clk) begin
        if (rst_n) begin
            if (!m_act) begin
                chk("m_pass_a", m_a, cpu_a);
                chk("m_pass_rw", m_rw, cpu_rw);
                chk("m_pass_d", m_dout, cpu_dout);
            end else if (!m_rw) begin
                m_last_rd = m_a;
            end else begin
                chk("m_wr_addr", m_a, 16'h2004);
                if (qm.size() == 0) miss("m_extra_wr");
                else begin
                    e_m = qm.pop_front();
                    chk("m_src_addr", m_last_rd, e_m.a);
                    chk("m_wr_data", m_dout, e_m.d);
                    wr_seen++;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (!s_act) begin
                chk("s_pass_a", s_a, cpu_a);
                chk("s_pass_rw", s_rw, cpu_rw);
            end else if (!s_rw) begin
                s_last_rd = s_a;
            end else begin
                chk("s_wr_addr", s_a, 16'h2004);
                if (qs.size() == 0) miss("s_extra_wr");
                else begin
                    e_s = qs.pop_front();
                    chk("s_src_addr", s_last_rd, e_s.a);
                    chk("s_wr_data", s_dout, e_s.d);
                end
            end
        end
    end

    // Stall-length monitors: each completed run of cpu_rdy=0 is scored.
    always @(negedge clk) begin
        if (!rst_n) run_m = 0;
        else if (!m_rdy) run_m++;
        else if (run_m > 0) begin
            if (stm.size() == 0) miss("m_stall_unexp");
            else chk("m_stall", run_m, stm.pop_front());
            run_m = 0;
        end
        if (!rst_n) run_s = 0;
        else if (!s_rdy) run_s++;
        else if (run_s > 0) begin
            if (sts.size() == 0) miss("s_stall_unexp");
            else chk("s_stall", run_s, sts.pop_front());
            run_s = 0;
        end
    end

    // Called and returns at posedge+1. nwr = extra CPU writes after the trigger.
    task automatic run_dma(input logic [7:0] pg, input int nwr, input int want_hpar,
                           input bit abort);
        int  xpar, align, base;
        bit  seen, done;
        xfer_t x;
        if (want_hpar >= 0)
            while (((pcnt + 1) & 1) != want_hpar) begin @(posedge clk); #1; end
        xpar = (pcnt + 1 + nwr) & 1;
`ifdef KDMA_ALIGN_EN
        align = (xpar == 0) ? 1 : 0;
`else
        align = 0;
`endif
        for (int i = 0; i < 256; i++) begin
            x.a = {pg, 8'(i)};
            x.d = 8'(i) ^ pg ^ 8'h58;
            qm.push_back(x);
            if (i < 4) qs.push_back(x);
        end
        if (!abort) stm.push_back(1 + nwr + align + 512);
        sts.push_back(1 + nwr + align + 8);
        cpu_rw = 1'b1; cpu_a = 16'h4014; cpu_dout = pg;
        @(posedge clk); #1;
        for (int j = 0; j < nwr; j++) begin
            cpu_rw = 1'b1; cpu_a = 16'h01FF - 16'(j); cpu_dout = 8'hC0 + 8'(j);
            @(posedge clk); #1;
        end
        cpu_rw = 1'b0; cpu_a = 16'h8000; cpu_dout = 8'h00;
        seen = 1'b0; done = 1'b0; base = wr_seen;
        for (int c = 0; c < 1200 && !done; c++) begin
            @(negedge clk);
            if (!seen && m_act) begin
                seen = 1'b1;
                chk("first_dma_addr", m_a, (align != 0) ? 16'h8000 : {pg, 8'h00});
            end
            if (abort && (wr_seen - base >= 100)) done = 1'b1;
            if (seen && m_rdy) begin
                done = 1'b1;
                chk("resume_read_a", m_a, 16'h8000);
                chk("resume_read_rw", m_rw, 1'b0);
            end
        end
        if (!done) miss("dma_timeout");
        @(posedge clk); #1;
        if (abort) begin
            rst_n = 1'b0;
            @(posedge clk); #1;
            rst_n = 1'b1;
            @(negedge clk);
            chk("abort_rdy", m_rdy, 1'b1);
            chk("abort_act", m_act, 1'b0);
            chk("abort_bus_a", m_a, cpu_a);
            chk("abort_bus_rw", m_rw, cpu_rw);
            qm.delete();
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rst_n = 1'b0; cpu_a = 16'h8000; cpu_dout = 8'h00; cpu_rw = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        cpu_a = 16'h0300; cpu_dout = 8'h77; cpu_rw = 1'b1;
        @(negedge clk);
        chk("rst_rdy", m_rdy, 1'b1);
        chk("rst_act", m_act, 1'b0);
        chk("rst_bus_a", m_a, 16'h0300);
        chk("rst_bus_d", m_dout, 8'h77);
        chk("rst_s_rdy", s_rdy, 1'b1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        cpu_a = 16'h8000; cpu_dout = 8'h00; cpu_rw = 1'b0;
        @(posedge clk); #1;

        run_dma(8'h02, 0, 1, 1'b0);
        run_dma(8'h10, 0, 0, 1'b0);
        run_dma(8'h03, 2, -1, 1'b0);
        run_dma(8'hFF, 0, -1, 1'b0);
        run_dma(8'h20, 0, -1, 1'b1);
        run_dma(8'h04, 0, -1, 1'b0);

        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("qm_empty", qm.size(), 0);
        chk("qs_empty", qs.size(), 0);
        chk("stm_empty", stm.size(), 0);
        chk("sts_empty", sts.size(), 0);
        chk("final_rdy", m_rdy, 1'b1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/kdma_ctrl.md
Name: kdma_ctrl

Overview:
- Sprite-DMA controller and bus arbiter for the k6502 system bus.
- A CPU write to the DMA register starts a block copy: 256 bytes from CPU page $XX00–$XXFF to a fixed destination port (PPU OAM data, $2004).
- It halts the CPU with `cpu_rdy`, takes ownership of the shared address/data/rw bus, performs read/write pairs, then hands the bus back.
- It sits between the k6502 core and the ROM/SRAM/PPU decode, and muxes all bus outputs.

Parameters:
- DMA_REG_ADDR, 16'h4014, CPU write address that triggers DMA; written data is the source page.
- DEST_ADDR, 16'h2004, fixed destination address for every DMA write.
- XFER_LEN, 256, bytes per transfer; legal range 1..256.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  synchronous active-low reset.
- cpu_a  in  16  CPU address.
- cpu_dout  in  8  CPU write data.
- cpu_rw  in  1  CPU direction, 1 = write, 0 = read.
- cpu_rdy  out  1  1 = CPU may proceed; 0 = CPU halted (repeats its read).
- bus_a  out  16  muxed system-bus address.
- bus_dout  out  8  muxed system-bus write data.
- bus_rw  out  1  muxed direction, 1 = write.
- bus_din  in  8  system-bus read data, valid combinationally within a read cycle.
- dma_active  out  1  1 while the controller owns the bus.

Behaviour:
- Reset: rst_n=0 sampled on a rising edge forces the following:
  - state=IDLE, cyc_par=0, idx=0, page=0, data latch=0.
  - cpu_rdy=1, dma_active=0.
  - Bus passes the CPU through.
  - Reset mid-transfer aborts the transfer immediately; there is no partial completion. The first cycle after reset is IDLE.
- cyc_par: toggles on every clock edge while rst_n=1. It is 0 in the first cycle after reset release.
- States: IDLE, HALT, ALIGN, READ, WRITE.
- IDLE:
  - Bus = CPU (bus_a=cpu_a, bus_dout=cpu_dout, bus_rw=cpu_rw).
  - cpu_rdy=1.
  - If cpu_rw=1 and cpu_a=DMA_REG_ADDR at an edge: page<=cpu_dout, idx<=0, go HALT.
  - The trigger write itself completes normally on the bus.
- HALT:
  - cpu_rdy=0, bus = CPU.
  - If cpu_rw=1 (CPU finishing a write sequence), stay in HALT.
  - Else, if cyc_par=1, go READ; if cyc_par=0, go ALIGN.
- ALIGN: one cycle. cpu_rdy=0, dma_active=1, bus_a=cpu_a, bus_rw=0 (dummy read). Go READ.
- READ:
  - cpu_rdy=0, dma_active=1.
  - bus_a={page, idx[7:0]}, bus_rw=0.
  - data latch<=bus_din at the closing edge. Go WRITE.
- WRITE:
  - cpu_rdy=0, dma_active=1.
  - bus_a=DEST_ADDR, bus_dout=latch, bus_rw=1.
  - If idx=XFER_LEN-1, go IDLE; else idx<=idx+1 and go READ.
- cpu_rdy and dma_active decode from registered state only; there are no combinational paths from CPU inputs to them.
- idx is 9 bits. Source address uses idx[7:0] only, so there is never a carry into the page: page $FF reads $FF00–$FFFF, no wrap into $0000.
- Stall length (cpu_rdy=0 cycles), with HALT exited on the first cycle:
  - 1 + 2*XFER_LEN when the HALT cycle has cyc_par=1.
  - 2 + 2*XFER_LEN when the HALT cycle has cyc_par=0.
  - For XFER_LEN=256 this is 513 or 514 cycles.
- DMA_REG_ADDR writes outside IDLE cannot occur, because the bus is not CPU-owned or the CPU is halted. If one is seen in HALT, it is ignored.
- Bus ownership changes only on clock edges, so there is never a cycle with mixed CPU/DMA address and rw.

Optional Feature:
- Macro: KDMA_ALIGN_EN.
- Defined: HALT→ALIGN/READ selection uses cyc_par as above, giving a 513/514-cycle stall.
- Undefined:
  - ALIGN state and cyc_par are removed.
  - HALT always goes to READ once cpu_rw=0.
  - Stall is always 1 + 2*XFER_LEN (513).

Test Plan:
- Basic copy: SRAM $0200–$02FF = idx^8'h5A; CPU writes $02 to $4014. Expected:
  - 256 bus writes to $2004 with data $5A,$5B,...,$A5 in idx order.
  - cpu_rdy returns to 1.
  - CPU resumes with its halted read repeated.
- Alignment (KDMA_ALIGN_EN): trigger so the HALT cycle has cyc_par=1 → exactly 513 cpu_rdy=0 cycles; cyc_par=0 → exactly 514, with one ALIGN dummy read at cpu_a.
- Write-sequence halt: trigger followed by two further CPU writes (e.g. JSR push) → HALT holds while cpu_rw=1, both writes appear on the bus, and the first DMA READ follows the first CPU read cycle.
- Page wrap: page $FF, XFER_LEN=256 → last source address $FFFF, no access to $0000.
- Reset mid-transfer: assert rst_n=0 for one edge after 100 writes → the next cycle shows cpu_rdy=1, dma_active=0, bus = CPU. A new trigger then restarts from idx 0.
- Short transfer: XFER_LEN=4, page $03 → exactly 4 writes to $2004 and 9 stall cycles (odd-parity HALT).
